traffic_phase_scheduler: RTL

- Demand-driven phase controller for the four-approach junction: M1, M2, MT (main turn) and S (side road).
- Latches per-approach requests and serves them round-robin. Each served approach gets a green/yellow/all-red sequence timed in 1 s ticks.
- Supports emergency-vehicle preemption on any approach.
- Sits after the 1 Hz tick divider and drives the lamp outputs directly, replacing the fixed-cycle sequencer when sensor inputs are fitted.

---
 rtl/traffic_phase_scheduler_if.sv | 30 +++
 rtl/traffic_phase_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler_if
//  Description : Demand, preemption and lamp-drive bundle for the phase scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_scheduler_if;
    logic       tick;
    logic [3:0] req;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [1:0] active;
    logic [2:0] state_o;
    logic [3:0] pending;

    modport slave (
        input  tick, req, emerg_req, emerg_dir,
        output light_M1, light_M2, light_MT, light_S, active, state_o, pending
    );

    modport master (
        output tick, req, emerg_req, emerg_dir,
        input  light_M1, light_M2, light_MT, light_S, active, state_o, pending
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler
//  Description : Round-robin demand-driven junction phase controller with preemption.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int GREEN_T  = 7,
    parameter int YEL_T    = 2,
    parameter int ALLRED_T = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_phase_scheduler_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_ALLRED = 3'd3,
        ST_EMERG  = 3'd4
    } state_t;

    localparam logic [3:0] C_GREEN_LD  = 4'(GREEN_T - 1);
    localparam logic [3:0] C_YEL_LD    = 4'(YEL_T - 1);
    localparam logic [3:0] C_ALLRED_LD = 4'(ALLRED_T - 1);
    localparam logic [2:0] C_RED       = 3'b100;

    state_t          state_q, state_d;
    logic [3:0]      timer_q, timer_d;
    logic [1:0]      active_q, active_d;
    logic [3:0]      pending_q, pending_d;
    logic [3:0][2:0] lights_q, lights_d;

    logic       w_rr_found;
    logic [1:0] w_rr_idx;
    logic [1:0] w_cand;
    logic [3:0] w_hold_mask;

    // Search starts one past the last served approach and ends on it.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = active_q;
        w_cand     = active_q;
        for (int k = 1; k <= 4; k++) begin
            w_cand = active_q + 2'(k);
            if (!w_rr_found && pending_q[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.emerg_req) begin
                    state_d  = ST_EMERG;
                    active_d = bus.emerg_dir;
                    timer_d  = 4'd0;
                end else if (w_rr_found) begin
                    state_d  = ST_GREEN;
                    active_d = w_rr_idx;
                    timer_d  = C_GREEN_LD;
                end
            end
            ST_GREEN: begin
                if (bus.emerg_req) begin
                    if (bus.emerg_dir == active_q) begin
                        state_d = ST_EMERG;
                        timer_d = 4'd0;
                    end else begin
                        state_d = ST_YELLOW;
                        timer_d = C_YEL_LD;
                    end
                end else if (bus.tick) begin
                    if (timer_q == 4'd0) begin
                        state_d = ST_YELLOW;
                        timer_d = C_YEL_LD;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            ST_YELLOW: begin
                if (bus.tick) begin
                    if (timer_q == 4'd0) begin
                        state_d = ST_ALLRED;
                        timer_d = C_ALLRED_LD;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            ST_ALLRED: begin
                if (bus.tick) begin
                    if (timer_q != 4'd0) begin
                        timer_d = timer_q - 4'd1;
                    end else if (bus.emerg_req) begin
                        state_d  = ST_EMERG;
                        active_d = bus.emerg_dir;
                        timer_d  = 4'd0;
                    end else if (w_rr_found) begin
                        state_d  = ST_GREEN;
                        active_d = w_rr_idx;
                        timer_d  = C_GREEN_LD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_EMERG: begin
                if (!bus.emerg_req) begin
                    state_d = ST_YELLOW;
                    timer_d = C_YEL_LD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 4'd0;
            end
        endcase
    end

    // A request for the approach currently showing green is absorbed, not latched.
    always_comb begin
        w_hold_mask = 4'd0;
        if (state_d == ST_GREEN || state_d == ST_EMERG) begin
            w_hold_mask = 4'b0001 << active_d;
        end
        pending_d = (pending_q | bus.req) & ~w_hold_mask;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lights_d[i] = C_RED;
            if (active_d == 2'(i)) begin
                if (state_d == ST_GREEN || state_d == ST_EMERG) begin
                    lights_d[i] = 3'b001;
                end else if (state_d == ST_YELLOW) begin
                    lights_d[i] = 3'b010;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= 4'd0;
            active_q  <= 2'd3;
            pending_q <= 4'd0;
            lights_q  <= {4{C_RED}};
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            lights_q  <= lights_d;
        end
    end

    assign bus.light_M1 = lights_q[0];
    assign bus.light_M2 = lights_q[1];
    assign bus.light_MT = lights_q[2];
    assign bus.light_S  = lights_q[3];
    assign bus.active   = active_q;
    assign bus.state_o  = state_q;
    assign bus.pending  = pending_q;
endmodule
`default_nettype wire
